// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of a combinational 4-bit ALU.
// Decodes instruction words and reads a private register file.
// Presents registered mode/operands to the ALU.
// Writes the ALU result back and emits store data.
module alu_issue_stage #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2,
  parameter int IW     = 3 + 3*REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [IW-1:0]     instr,
  output logic              instr_ready,
  input  logic              stall,
  output logic [2:0]        alu_mode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              st_valid,
  output logic [DATA_W-1:0] st_data,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned DEPTH = 2**REG_AW;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_LOAD  = 3'b010,
    OP_STORE = 3'b011,
    OP_LOADC = 3'b100
  } op_e;

  // Register file and EX stage
  logic [DATA_W-1:0] r_rf [DEPTH];
  op_e               r_mode;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [REG_AW-1:0] r_rd;
  logic              r_wr;
  logic              r_st;

  // Decode results
  logic [2:0]        w_opc;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_accept;
  op_e               w_mode;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic              w_wr;
  logic              w_st;

  assign instr_ready = !stall;
  assign w_accept    = instr_valid && !stall;

  assign w_opc = instr[IW-1:IW-3];
  assign w_rd  = instr[3*REG_AW-1:2*REG_AW];
  assign w_rs  = instr[2*REG_AW-1:REG_AW];
  assign w_rt  = instr[REG_AW-1:0];
  assign w_imm = instr[DATA_W-1:0];

  assign alu_mode = r_mode;
  assign alu_op1  = r_op1;
  assign alu_op2  = r_op2;
  assign dbg_data = r_rf[dbg_sel];

  // Operand read with bypass of the result that retires on this same edge
  always_comb begin
    w_rs_val = (r_wr && (r_rd == w_rs)) ? alu_result : r_rf[w_rs];
    w_rt_val = (r_wr && (r_rd == w_rt)) ? alu_result : r_rf[w_rt];
  end

  // Instruction decode into next EX contents; no accept yields a bubble
  always_comb begin
    w_mode = OP_NOP;
    w_op1  = '0;
    w_op2  = '0;
    w_wr   = 1'b0;
    w_st   = 1'b0;
    if (w_accept) begin
      case (w_opc)
        OP_ADD: begin
          w_mode = OP_ADD;
          w_op1  = w_rs_val;
          w_op2  = w_rt_val;
          w_wr   = 1'b1;
        end
        OP_LOAD: begin
          w_mode = OP_LOAD;
          w_op1  = w_rs_val;
          w_wr   = 1'b1;
        end
        OP_STORE: begin
          w_mode = OP_STORE;
          w_op1  = w_rs_val;
          w_st   = 1'b1;
        end
        OP_LOADC: begin
          w_mode = OP_LOADC;
          w_op1  = w_imm;
          w_wr   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Retire the EX instruction and load the next one unless stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_rf[i] <= '0;
      r_mode   <= OP_NOP;
      r_op1    <= '0;
      r_op2    <= '0;
      r_rd     <= '0;
      r_wr     <= 1'b0;
      r_st     <= 1'b0;
      st_valid <= 1'b0;
      st_data  <= '0;
    end else if (stall) begin
      st_valid <= 1'b0;
    end else begin
      if (r_wr) r_rf[r_rd] <= alu_result;
      st_valid <= r_st;
      if (r_st) st_data <= alu_result;
      r_mode <= w_mode;
      r_op1  <= w_op1;
      r_op2  <= w_op2;
      r_rd   <= w_rd;
      r_wr   <= w_wr;
      r_st   <= w_st;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU attached.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic       stall;
  logic [2:0] alu_mode;
  logic [3:0] alu_op1, alu_op2, alu_result;
  logic       st_valid;
  logic [3:0] st_data;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_stage #(.DATA_W(4), .REG_AW(2), .IW(9)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .stall(stall), .alu_mode(alu_mode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .st_valid(st_valid), .st_data(st_data), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Downstream ALU: ADD sums, LOAD/STORE/LOADC pass operand1, NOP gives 0
  always_comb begin
    case (alu_mode)
      3'd1:             alu_result = alu_op1 + alu_op2;
      3'd2, 3'd3, 3'd4: alu_result = alu_op1;
      default:          alu_result = 4'd0;
    endcase
  end

  typedef struct {
    logic       v;
    logic [8:0] ins;
    logic [2:0] m;
    logic [3:0] o1;
    logic [3:0] o2;
    logic       sv;
    logic [3:0] sd;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [8:0] mkc(input logic [1:0] rd, input logic [3:0] imm);
    return {3'b100, rd, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string name, input logic [3:0] e0, input logic [3:0] e1,
                          input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s_R%0d", name, i), {28'd0, dbg_data}, {28'd0, exp[i]});
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; stall = 1'b0; dbg_sel = '0;

    // Main sequence: forwarding, wrap, stores, undefined opcode, LOAD move
    tbl[0]  = '{1'b1, mkc(2'd1, 4'd5),           3'd4, 4'd5, 4'd0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, mkc(2'd2, 4'd3),           3'd4, 4'd3, 4'd0, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, mk(3'b001, 2'd3, 2'd1, 2'd2), 3'd1, 4'd5, 4'd3, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, mk(3'b011, 2'd0, 2'd3, 2'd0), 3'd3, 4'd8, 4'd0, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, mk(3'b001, 2'd0, 2'd1, 2'd1), 3'd0, 4'd0, 4'd0, 1'b1, 4'd8};
    tbl[5]  = '{1'b1, mkc(2'd0, 4'hF),           3'd4, 4'hF, 4'd0, 1'b0, 4'd0};
    tbl[6]  = '{1'b1, mkc(2'd1, 4'd1),           3'd4, 4'd1, 4'd0, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, mk(3'b001, 2'd2, 2'd0, 2'd1), 3'd1, 4'hF, 4'd1, 1'b0, 4'd0};
    tbl[8]  = '{1'b1, mk(3'b011, 2'd0, 2'd2, 2'd0), 3'd3, 4'd0, 4'd0, 1'b0, 4'd0};
    tbl[9]  = '{1'b1, mk(3'b001, 2'd0, 2'd0, 2'd0), 3'd1, 4'hF, 4'hF, 1'b1, 4'd0};
    tbl[10] = '{1'b1, mk(3'b011, 2'd0, 2'd0, 2'd0), 3'd3, 4'hE, 4'd0, 1'b0, 4'd0};
    tbl[11] = '{1'b1, mk(3'b111, 2'd3, 2'd1, 2'd2), 3'd0, 4'd0, 4'd0, 1'b1, 4'hE};
    tbl[12] = '{1'b1, mk(3'b010, 2'd3, 2'd1, 2'd0), 3'd2, 4'd1, 4'd0, 1'b0, 4'd0};
    tbl[13] = '{1'b0, mk(3'b011, 2'd0, 2'd3, 2'd0), 3'd0, 4'd0, 4'd0, 1'b0, 4'd0};
    tbl[14] = '{1'b1, mk(3'b011, 2'd0, 2'd3, 2'd0), 3'd3, 4'd1, 4'd0, 1'b0, 4'd0};
    tbl[15] = '{1'b0, 9'd0,                      3'd0, 4'd0, 4'd0, 1'b1, 4'd1};

    // Reset state
    #12;
    chk("rst_mode", {29'd0, alu_mode}, 32'd0);
    chk("rst_stv", {31'd0, st_valid}, 32'd0);
    chk_regs("rst", 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      instr_valid = tbl[i].v;
      instr       = tbl[i].ins;
      chk($sformatf("v%0d_ready", i), {31'd0, instr_ready}, 32'd1);
      step();
      chk($sformatf("v%0d_mode", i), {29'd0, alu_mode}, {29'd0, tbl[i].m});
      chk($sformatf("v%0d_op1", i), {28'd0, alu_op1}, {28'd0, tbl[i].o1});
      chk($sformatf("v%0d_op2", i), {28'd0, alu_op2}, {28'd0, tbl[i].o2});
      chk($sformatf("v%0d_stv", i), {31'd0, st_valid}, {31'd0, tbl[i].sv});
      if (tbl[i].sv) chk($sformatf("v%0d_std", i), {28'd0, st_data}, {28'd0, tbl[i].sd});
    end
    instr_valid = 1'b0;
    chk_regs("tbl", 4'hE, 4'd1, 4'd0, 4'd1);

    // ADD held in EX under stall, writes once on release
    instr_valid = 1'b1; instr = mkc(2'd2, 4'd6);
    step();
    instr = mk(3'b001, 2'd3, 2'd2, 2'd1);
    step();
    chk("stl_fwd_op1", {28'd0, alu_op1}, 32'd6);
    chk("stl_fwd_op2", {28'd0, alu_op2}, 32'd1);
    stall = 1'b1; instr = mkc(2'd0, 4'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stl%0d_ready", c), {31'd0, instr_ready}, 32'd0);
      step();
      chk($sformatf("stl%0d_mode", c), {29'd0, alu_mode}, 32'd1);
      chk($sformatf("stl%0d_op1", c), {28'd0, alu_op1}, 32'd6);
      chk($sformatf("stl%0d_op2", c), {28'd0, alu_op2}, 32'd1);
      dbg_sel = 2'd3; #1;
      chk($sformatf("stl%0d_R3", c), {28'd0, dbg_data}, 32'd1);
    end
    stall = 1'b0; instr_valid = 1'b0;
    dbg_sel = 2'd3; #1;
    chk("rel_old_R3", {28'd0, dbg_data}, 32'd1);
    step();
    chk("rel_mode", {29'd0, alu_mode}, 32'd0);
    chk_regs("rel", 4'hE, 4'd1, 4'd6, 4'd7);

    // STORE held under stall: no strobe until release, then exactly one
    instr_valid = 1'b1; instr = mk(3'b011, 2'd0, 2'd3, 2'd0);
    step();
    stall = 1'b1; instr_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("sst%0d_stv", c), {31'd0, st_valid}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("sst_rel_stv", {31'd0, st_valid}, 32'd1);
    chk("sst_rel_std", {28'd0, st_data}, 32'd7);
    step();
    chk("sst_end_stv", {31'd0, st_valid}, 32'd0);

    // Asynchronous reset with a writing instruction in EX
    instr_valid = 1'b1; instr = mkc(2'd1, 4'hA);
    step();
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_mode", {29'd0, alu_mode}, 32'd0);
    chk("mrst_op1", {28'd0, alu_op1}, 32'd0);
    chk("mrst_op2", {28'd0, alu_op2}, 32'd0);
    chk("mrst_stv", {31'd0, st_valid}, 32'd0);
    chk("mrst_std", {28'd0, st_data}, 32'd0);
    chk_regs("mrst", 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_stv", {31'd0, st_valid}, 32'd0);
    chk_regs("post_rst", 4'd0, 4'd0, 4'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
